// File: rtl/lsu_port_arbiter.sv
// Two-port arbiter in front of the single LSU port: one transaction in flight at a time,
// completion (stall_next=0, fault) steered back only to the port that owns it.
module lsu_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_prev_stalled,
    input  logic [2*ADDR_W-1:0]     req_addr,
    input  logic [1:0]              req_do_load,
    input  logic [1:0]              req_do_store,
    input  logic [2*DATA_W-1:0]     req_store_data,
    input  logic [2*(DATA_W/8)-1:0] req_store_mask,
    output logic [1:0]              req_stall_next,
    output logic [DATA_W-1:0]       req_load_data,
    output logic [1:0]              req_access_fault,
    output logic                    lsu_prev_stalled,
    input  logic                    lsu_stall_next,
    output logic [ADDR_W-1:0]       lsu_addr,
    output logic                    lsu_do_load,
    output logic                    lsu_do_store,
    output logic [DATA_W-1:0]       lsu_store_data,
    output logic [DATA_W/8-1:0]     lsu_store_mask,
    input  logic [DATA_W-1:0]       lsu_load_data,
    input  logic                    lsu_access_fault,
    output logic                    arb_busy,
    output logic                    arb_owner
);
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              load_q, load_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;

    logic [1:0]        req_valid;
    logic              winner;
    logic              issue;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_sdata;
    logic [MASK_W-1:0] win_mask;
    logic              win_load;
    logic              win_store;

    always_comb begin
        req_valid = ~req_prev_stalled;
        issue     = (state_q == StIdle) && !rst && (req_valid != 2'b00);
        if (req_valid == 2'b11) begin
            winner = (PRIO_MODE != 0) ? 1'b0 : ~last_q;
        end else begin
            winner = req_valid[1];
        end
        win_addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        win_sdata = winner ? req_store_data[2*DATA_W-1:DATA_W] : req_store_data[DATA_W-1:0];
        win_mask  = winner ? req_store_mask[2*MASK_W-1:MASK_W] : req_store_mask[MASK_W-1:0];
        win_load  = req_do_load[winner];
        win_store = req_do_store[winner];
    end

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_d           = last_q;
        load_d           = load_q;
        store_d          = store_q;
        addr_d           = addr_q;
        sdata_d          = sdata_q;
        mask_d           = mask_q;
        lsu_prev_stalled = 1'b1;
        lsu_addr         = addr_q;
        lsu_do_load      = load_q;
        lsu_do_store     = store_q;
        lsu_store_data   = sdata_q;
        lsu_store_mask   = mask_q;
        req_stall_next   = 2'b11;
        req_access_fault = 2'b00;
        arb_busy         = 1'b0;
        case (state_q)
            StIdle: begin
                lsu_do_load  = 1'b0;
                lsu_do_store = 1'b0;
                if (issue) begin
                    // Winner goes straight through to the LSU in the same cycle.
                    lsu_prev_stalled = 1'b0;
                    lsu_addr         = win_addr;
                    lsu_do_load      = win_load;
                    lsu_do_store     = win_store;
                    lsu_store_data   = win_sdata;
                    lsu_store_mask   = win_mask;
                    state_d          = StBusy;
                    owner_d          = winner;
                    last_d           = winner;
                    load_d           = win_load;
                    store_d          = win_store;
                    addr_d           = win_addr;
                    sdata_d          = win_sdata;
                    mask_d           = win_mask;
                end
            end
            StBusy: begin
                arb_busy = 1'b1;
                // A reset in the completion cycle swallows the result.
                if (!lsu_stall_next && !rst) begin
                    req_stall_next[owner_q]   = 1'b0;
                    req_access_fault[owner_q] = lsu_access_fault;
                    state_d                   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_load_data = lsu_load_data;
    assign arb_owner     = owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            load_q  <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            load_q  <= load_d;
            store_q <= store_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        sdata_q <= sdata_d;
        mask_q  <= mask_d;
    end

    assert property (@(posedge clk) disable iff (rst)
        (req_stall_next != 2'b00) && ((state_q == StIdle) -> (req_stall_next == 2'b11)));

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Bench for lsu_port_arbiter: round-robin and fixed-priority instances share stimulus;
// a scoreboard of expected completions is checked by an independent monitor.
module tb_lsu_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = DW / 8;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        logic          fault;
        int            cyc;
    } exp_t;

    logic            clk;
    logic            rst0, rst1, sel;
    logic [1:0]      req_prev_stalled;
    logic [2*AW-1:0] req_addr;
    logic [1:0]      req_do_load, req_do_store;
    logic [2*DW-1:0] req_store_data;
    logic [2*MW-1:0] req_store_mask;
    logic            lsu_stall_next, lsu_access_fault;
    logic [DW-1:0]   lsu_load_data;

    logic [1:0]    o0_stall, o0_fault, o1_stall, o1_fault;
    logic [DW-1:0] o0_ldata, o1_ldata, o0_sdata, o1_sdata;
    logic          o0_prev, o1_prev, o0_load, o1_load, o0_store, o1_store;
    logic [AW-1:0] o0_addr, o1_addr;
    logic [MW-1:0] o0_mask, o1_mask;
    logic          o0_busy, o1_busy, o0_owner, o1_owner;

    logic          a_rst, a_prev;
    logic [1:0]    a_stall, a_fault;
    logic [DW-1:0] a_ldata;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc_cnt = 0;
    int            lsu_lat = 1;
    int            lsu_cnt = 0;
    logic          fault_cfg, force_done;
    logic [DW-1:0] rdata_cfg;
    exp_t          sb[$];

    lsu_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst0),
        .req_prev_stalled(req_prev_stalled), .req_addr(req_addr),
        .req_do_load(req_do_load), .req_do_store(req_do_store),
        .req_store_data(req_store_data), .req_store_mask(req_store_mask),
        .req_stall_next(o0_stall), .req_load_data(o0_ldata), .req_access_fault(o0_fault),
        .lsu_prev_stalled(o0_prev), .lsu_stall_next(lsu_stall_next), .lsu_addr(o0_addr),
        .lsu_do_load(o0_load), .lsu_do_store(o0_store), .lsu_store_data(o0_sdata),
        .lsu_store_mask(o0_mask), .lsu_load_data(lsu_load_data),
        .lsu_access_fault(lsu_access_fault), .arb_busy(o0_busy), .arb_owner(o0_owner)
    );

    lsu_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst1),
        .req_prev_stalled(req_prev_stalled), .req_addr(req_addr),
        .req_do_load(req_do_load), .req_do_store(req_do_store),
        .req_store_data(req_store_data), .req_store_mask(req_store_mask),
        .req_stall_next(o1_stall), .req_load_data(o1_ldata), .req_access_fault(o1_fault),
        .lsu_prev_stalled(o1_prev), .lsu_stall_next(lsu_stall_next), .lsu_addr(o1_addr),
        .lsu_do_load(o1_load), .lsu_do_store(o1_store), .lsu_store_data(o1_sdata),
        .lsu_store_mask(o1_mask), .lsu_load_data(lsu_load_data),
        .lsu_access_fault(lsu_access_fault), .arb_busy(o1_busy), .arb_owner(o1_owner)
    );

    assign a_rst   = sel ? rst1 : rst0;
    assign a_prev  = sel ? o1_prev : o0_prev;
    assign a_stall = sel ? o1_stall : o0_stall;
    assign a_fault = sel ? o1_fault : o0_fault;
    assign a_ldata = sel ? o1_ldata : o0_ldata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // LSU model: completes in the lsu_lat-th cycle after the issue cycle.
    always @(posedge clk) begin
        if (a_rst) lsu_cnt <= 0;
        else if (a_prev == 1'b0) lsu_cnt <= lsu_lat;
        else if (lsu_cnt > 0) lsu_cnt <= lsu_cnt - 1;
    end
    assign lsu_stall_next   = !((lsu_cnt == 1) || force_done);
    assign lsu_access_fault = (lsu_cnt == 1) && fault_cfg;
    assign lsu_load_data    = rdata_cfg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [DW-1:0] d, input logic f,
                                input int c);
        exp_t e;
        e.port  = p;
        e.data  = d;
        e.fault = f;
        e.cyc   = c;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!a_rst && a_stall !== 2'b11) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", 64'(a_stall), 64'h3);
            end else begin
                e = sb.pop_front();
                check("cpl_stall", 64'(a_stall), e.port ? 64'h1 : 64'h2);
                check("cpl_fault", 64'(a_fault), !e.fault ? 64'h0 : (e.port ? 64'h2 : 64'h1));
                check("cpl_data", a_ldata, e.data);
                check("cpl_cycle", 64'(cyc_cnt), 64'(e.cyc));
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);
        rst0 = sel;
        rst1 = !sel;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
        req_prev_stalled = 2'b11; req_addr = '0; req_do_load = '0; req_do_store = '0;
        req_store_data = '0; req_store_mask = '0;
        fault_cfg = 1'b0; force_done = 1'b0; rdata_cfg = 64'hDEADBEEF_CAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(o0_busy), 64'h0);
        check("rst_owner", 64'(o0_owner), 64'h0);
        check("rst_stall", 64'(o0_stall), 64'h3);
        check("rst_fault", 64'(o0_fault), 64'h0);
        check("rst_prev", 64'(o0_prev), 64'h1);
        check("rst_load", 64'(o0_load), 64'h0);
        check("rst_store", 64'(o0_store), 64'h0);

        // 1: port 0 load, latency 2
        sel = 1'b0; reset_dut(); lsu_lat = 2;
        req_addr[AW-1:0] = 32'h10; req_do_load = 2'b01; req_prev_stalled = 2'b10;
        c = cyc_cnt;
        sb.push_back(mk(1'b0, 64'hDEADBEEF_CAFEF00D, 1'b0, c + 2));
        #1;
        check("t1_issue_prev", 64'(o0_prev), 64'h0);
        check("t1_issue_addr", 64'(o0_addr), 64'h10);
        check("t1_issue_load", 64'(o0_load), 64'h1);
        @(negedge clk);
        req_prev_stalled = 2'b11;
        #1;
        check("t1_busy", 64'(o0_busy), 64'h1);
        check("t1_owner", 64'(o0_owner), 64'h0);
        repeat (4) @(negedge clk);

        // 2: round-robin, both ports requesting, latency 1
        sel = 1'b0; reset_dut(); lsu_lat = 1; rdata_cfg = 64'h0123_4567_89AB_CDEF;
        req_addr = {32'h200, 32'h100}; req_do_load = 2'b11; req_prev_stalled = 2'b00;
        c = cyc_cnt;
        for (int k = 0; k < 4; k++) sb.push_back(mk(k[0], rdata_cfg, 1'b0, c + 1 + 2 * k));
        repeat (8) @(negedge clk);
        req_prev_stalled = 2'b11;
        repeat (3) @(negedge clk);

        // 3: fixed priority, port 0 hogs for 8 transactions, then port 1 gets in
        sel = 1'b1; reset_dut(); lsu_lat = 1;
        req_prev_stalled = 2'b00;
        c = cyc_cnt;
        for (int k = 0; k < 8; k++) sb.push_back(mk(1'b0, rdata_cfg, 1'b0, c + 1 + 2 * k));
        sb.push_back(mk(1'b1, rdata_cfg, 1'b0, c + 17));
        repeat (16) @(negedge clk);
        req_prev_stalled = 2'b01;
        repeat (2) @(negedge clk);
        req_prev_stalled = 2'b11;
        repeat (3) @(negedge clk);

        // 4: port 1 store held stable while port 0 churns its address
        sel = 1'b0; reset_dut(); lsu_lat = 3; rdata_cfg = 64'hA5A5_5A5A_0F0F_F0F0;
        req_addr[2*AW-1:AW] = 32'h300; req_do_load = 2'b00; req_do_store = 2'b10;
        req_store_data[2*DW-1:DW] = 64'h1122_3344_5566_7788;
        req_store_mask[2*MW-1:MW] = 8'h0F;
        req_prev_stalled = 2'b01;
        c = cyc_cnt;
        sb.push_back(mk(1'b1, rdata_cfg, 1'b0, c + 3));
        sb.push_back(mk(1'b0, rdata_cfg, 1'b0, c + 7));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req_prev_stalled = 2'b10;
            req_do_load      = 2'b01;
            req_addr[AW-1:0] = 32'h1000 + 32'(k * 4);
            #1;
            check("t4_addr", 64'(o0_addr), 64'h300);
            check("t4_sdata", o0_sdata, 64'h1122_3344_5566_7788);
            check("t4_mask", 64'(o0_mask), 64'h0F);
            check("t4_store", 64'(o0_store), 64'h1);
            check("t4_load", 64'(o0_load), 64'h0);
            check("t4_prev", 64'(o0_prev), 64'h1);
        end
        repeat (2) @(negedge clk);
        req_prev_stalled = 2'b11; req_do_store = 2'b00;
        repeat (4) @(negedge clk);

        // 5: port 0 load faults
        sel = 1'b0; reset_dut(); lsu_lat = 2; fault_cfg = 1'b1;
        req_addr[AW-1:0] = 32'h40; req_do_load = 2'b01; req_prev_stalled = 2'b10;
        c = cyc_cnt;
        sb.push_back(mk(1'b0, rdata_cfg, 1'b1, c + 2));
        @(negedge clk);
        req_prev_stalled = 2'b11;
        repeat (4) @(negedge clk);
        fault_cfg = 1'b0;

        // 6: reset mid-BUSY drops the transaction
        sel = 1'b0; reset_dut(); lsu_lat = 3;
        req_prev_stalled = 2'b10;
        @(negedge clk);
        req_prev_stalled = 2'b11;
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        check("t6_busy", 64'(o0_busy), 64'h0);
        check("t6_stall", 64'(o0_stall), 64'h3);
        @(negedge clk);
        force_done = 1'b1;
        #1;
        check("t6_forced_stall", 64'(o0_stall), 64'h3);
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_port_arbiter.md
Name: lsu_port_arbiter

Overview:
Shares the single load/store unit port between two requesters. Port 0 is the exec_mem data path; port 1 is the page-table walker or any other secondary memory client.
The block grants one transaction at a time and holds the grant until the LSU completes. It returns load data and the fault flag only to the owner and keeps every non-owner stalled.
It sits between the requesters and the LSU/cache. The requester-facing signal convention matches the LSU's own, so requesters connect to it as if it were the LSU.

Parameters:
ADDR_W, basic_cache_params::aligned_addr_size, cache-line-aligned address width
DATA_W, `XLEN, load/store data width
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority to port 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
req_prev_stalled  in  2  per port; 0 = request presented this cycle
req_addr  in  2*ADDR_W  per-port aligned address
req_do_load  in  2  per-port load flag
req_do_store  in  2  per-port store flag
req_store_data  in  2*DATA_W  per-port store data
req_store_mask  in  2*(DATA_W/8)  per-port byte mask
req_stall_next  out  2  per port; 0 only in that port's completion cycle
req_load_data  out  DATA_W  shared load data, valid for the owner in its completion cycle
req_access_fault  out  2  per-port fault flag, valid only in that port's completion cycle
lsu_prev_stalled  out  1  0 = request issued to LSU this cycle
lsu_stall_next  in  1  0 = LSU completes the outstanding transaction
lsu_addr  out  ADDR_W  address to LSU
lsu_do_load  out  1  load flag to LSU
lsu_do_store  out  1  store flag to LSU
lsu_store_data  out  DATA_W  store data to LSU
lsu_store_mask  out  DATA_W/8  byte mask to LSU
lsu_load_data  in  DATA_W  load data from LSU
lsu_access_fault  in  1  fault flag from LSU
arb_busy  out  1  high while a transaction is outstanding
arb_owner  out  1  index of the current or last granted port

Behaviour:
- FSM has two states, IDLE and BUSY. Reset puts the block in IDLE with last_grant=1, so port 0 wins the first tie.
- Values after reset (rst high):
  - arb_busy=0, arb_owner=0
  - req_stall_next=2'b11, req_access_fault=0
  - lsu_prev_stalled=1, lsu_do_load=0, lsu_do_store=0
- IDLE:
  - Requesting ports are those with req_prev_stalled[i]=0.
  - If none request: lsu_prev_stalled=1 and downstream address/data outputs are don't-care.
  - Otherwise one winner is picked combinationally. PRIO_MODE=0: if both request, the port != last_grant wins. PRIO_MODE=1: port 0 always wins.
  - The winner's addr, load/store flags, data and mask pass combinationally to the LSU, with lsu_prev_stalled=0 in the same cycle (zero added issue latency).
  - Next edge: capture the winner's request into a holding register, set owner=winner and last_grant=winner, go to BUSY.
  - Each req_stall_next[i] is 1 in IDLE; the losing port simply keeps presenting its request.
- BUSY:
  - lsu_prev_stalled=1. LSU address/data outputs come from the holding register and stay stable.
  - arb_busy=1.
  - While lsu_stall_next=1: req_stall_next=2'b11.
  - When lsu_stall_next=0 (completion cycle):
    - req_stall_next[owner]=0 and req_access_fault[owner]=lsu_access_fault.
    - req_load_data=lsu_load_data, passed combinationally.
    - The non-owner keeps stall_next=1 and fault=0.
    - Next state is IDLE.
- Minimum spacing is one IDLE cycle between completion and the next issue. Back-to-back issue in the completion cycle is not allowed.
- lsu_stall_next is ignored in IDLE. No completion is ever attributed in IDLE.
- A requester that raises req_prev_stalled while it owns BUSY does not cancel the transaction. It still receives its completion.
- A store completion drives req_load_data=lsu_load_data, which is don't-care. The requester handles this case.
- If lsu_do_load and lsu_do_store are both 1 in an issued request, they are forwarded unchanged. No checking is done.
- rst asserted in BUSY: return to IDLE on that edge and drop the in-flight result. No stall_next=0 pulse reaches any requester. The LSU is reset by the same rst.
- Invariant (assertion): at most one bit of req_stall_next is 0 in any cycle, and never in IDLE.

Test Plan:
1. Port 0 alone, load at addr 0x10, LSU completes 2 cycles after issue:
   - issue cycle has lsu_prev_stalled=0, lsu_addr=0x10
   - req_stall_next=2'b10 exactly once, 2 cycles later, with req_load_data=0xDEADBEEF_CAFEF00D
2. Both ports request continuously, PRIO_MODE=0, LSU latency 1: grant order is 0,1,0,1 across four transactions, and each completion goes only to its owner.
3. Both request, PRIO_MODE=1, port 0 requests continuously: port 1 is never granted over 8 transactions; it is granted in the first IDLE where port 0 is idle.
4. Port 1 store (mask 0x0F, data 0x1122334455667788), with port 0 changing its req_addr every cycle during a 3-cycle BUSY: lsu_addr, data and mask stay at port 1's values for the whole of BUSY.
5. Port 0 load faults (lsu_access_fault=1 on completion): req_access_fault=2'b01 for one cycle; port 1 sees no fault.
6. rst asserted in the middle of BUSY: the next cycle shows arb_busy=0 and req_stall_next=2'b11. A later LSU stall_next=0 with no new request produces no completion pulse.
